// File: rtl/qspi_host.sv
// Quad-SPI host: sends one framed transaction (cmd, addr, optional dummy, 32-bit data)
// per valid/ready request and returns read data with a one-cycle valid pulse.
`default_nettype none

module qspi_host #(
    parameter int CLK_DIV      = 2,
    parameter int DUMMY_CYCLES = 8,
    parameter int CS_IDLE      = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [7:0]  req_cmd_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        spi_cs_no,
    output logic        spi_sck_o,
    output logic [3:0]  spi_io_o,
    output logic        spi_io_oe_o,
    input  logic [3:0]  spi_io_i
);

    localparam logic [7:0] HP_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] DUMMY_N  = 5'(DUMMY_CYCLES);
    localparam int         GAP_W    = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_IDLE - 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CS_SETUP = 4'd1,
        ST_CMD      = 4'd2,
        ST_ADDR     = 4'd3,
        ST_DUMMY    = 4'd4,
        ST_WDATA    = 4'd5,
        ST_RDATA    = 4'd6,
        ST_CS_HOLD  = 4'd7,
        ST_CS_GAP   = 4'd8
    } state_t;

    state_t           state_q;
    logic [7:0]       hp_q;
    logic [4:0]       cnt_q;
    logic [GAP_W-1:0] gap_q;
    logic [67:0]      tx_q;
    logic [31:0]      rx_q;
    logic             write_q;
    logic             ready_q;
    logic             rsp_valid_q;
    logic [31:0]      rdata_q;
    logic             cs_n_q;
    logic             sck_q;
    logic [3:0]       io_q;
    logic             oe_q;

    logic tick;
    assign tick = (hp_q == HP_LAST);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            hp_q        <= 8'd0;
            cnt_q       <= 5'd0;
            gap_q       <= '0;
            tx_q        <= '0;
            rx_q        <= 32'd0;
            write_q     <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            io_q        <= 4'd0;
            oe_q        <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            hp_q        <= (tick || state_q == ST_IDLE) ? 8'd0 : hp_q + 8'd1;

            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        write_q <= req_write_i;
                        tx_q    <= {req_cmd_i[3:0], req_addr_i, req_wdata_i};
                        io_q    <= req_cmd_i[7:4];
                        cs_n_q  <= 1'b0;
                        oe_q    <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= ST_CS_SETUP;
                    end
                end

                ST_CS_SETUP: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        cnt_q   <= 5'd2;
                        state_q <= ST_CMD;
                    end
                end

                ST_CMD, ST_ADDR, ST_DUMMY, ST_WDATA, ST_RDATA: begin
                    if (tick) begin
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                            if (state_q == ST_RDATA) begin
                                rx_q <= {rx_q[27:0], spi_io_i};
                            end
                        end else begin
                            // Falling edge: advance the outgoing nibble stream and the phase count.
                            sck_q <= 1'b0;
                            io_q  <= tx_q[67:64];
                            tx_q  <= {tx_q[63:0], 4'd0};
                            cnt_q <= cnt_q - 5'd1;
                            if (cnt_q == 5'd1) begin
                                case (state_q)
                                    ST_CMD: begin
                                        cnt_q   <= 5'd8;
                                        state_q <= ST_ADDR;
                                    end
                                    ST_ADDR: begin
                                        cnt_q <= 5'd8;
                                        if (write_q) begin
                                            state_q <= ST_WDATA;
                                        end else begin
                                            oe_q <= 1'b0;
                                            io_q <= 4'd0;
                                            tx_q <= '0;
                                            if (DUMMY_N != 5'd0) begin
                                                cnt_q   <= DUMMY_N;
                                                state_q <= ST_DUMMY;
                                            end else begin
                                                state_q <= ST_RDATA;
                                            end
                                        end
                                    end
                                    ST_DUMMY: begin
                                        cnt_q   <= 5'd8;
                                        state_q <= ST_RDATA;
                                    end
                                    default: begin
                                        io_q    <= 4'd0;
                                        state_q <= ST_CS_HOLD;
                                    end
                                endcase
                            end
                        end
                    end
                end

                ST_CS_HOLD: begin
                    if (tick) begin
                        cs_n_q      <= 1'b1;
                        oe_q        <= 1'b0;
                        io_q        <= 4'd0;
                        rsp_valid_q <= 1'b1;
                        if (!write_q) begin
                            rdata_q <= rx_q;
                        end
                        gap_q   <= GAP_LAST;
                        state_q <= ST_CS_GAP;
                    end
                end

                ST_CS_GAP: begin
                    if (gap_q == '0) begin
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - GAP_W'(1);
                    end
                end

                default: begin
                    ready_q <= 1'b1;
                    cs_n_q  <= 1'b1;
                    sck_q   <= 1'b0;
                    oe_q    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign spi_cs_no   = cs_n_q;
    assign spi_sck_o   = sck_q;
    assign spi_io_o    = io_q;
    assign spi_io_oe_o = oe_q;

endmodule

`default_nettype wire

// File: tb/tb_qspi_host.sv
// Scoreboard bench for qspi_host: two instances (CLK_DIV=2/DUMMY=8 and CLK_DIV=1/DUMMY=0)
// with a sampled-bus sniffer and a mode-0 responder.
`default_nettype none

module tb_qspi_host;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  valid = '0, wr = '0;
    logic [7:0]  cmd   [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [1:0]  ready, rspv, cs_n, sck, oe;
    logic [31:0] rdata [2];
    logic [3:0]  io_o  [2];
    logic [3:0]  io_i  [2];

    qspi_host #(.CLK_DIV(2), .DUMMY_CYCLES(8), .CS_IDLE(4)) u_a (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_valid_i(valid[0]), .req_ready_o(ready[0]), .req_write_i(wr[0]),
        .req_cmd_i(cmd[0]), .req_addr_i(addr[0]), .req_wdata_i(wd[0]),
        .rsp_valid_o(rspv[0]), .rsp_rdata_o(rdata[0]),
        .spi_cs_no(cs_n[0]), .spi_sck_o(sck[0]), .spi_io_o(io_o[0]),
        .spi_io_oe_o(oe[0]), .spi_io_i(io_i[0])
    );

    qspi_host #(.CLK_DIV(1), .DUMMY_CYCLES(0), .CS_IDLE(4)) u_b (
        .clk_i(clk), .reset_n_i(rst_n),
        .req_valid_i(valid[1]), .req_ready_o(ready[1]), .req_write_i(wr[1]),
        .req_cmd_i(cmd[1]), .req_addr_i(addr[1]), .req_wdata_i(wd[1]),
        .rsp_valid_o(rspv[1]), .rsp_rdata_o(rdata[1]),
        .spi_cs_no(cs_n[1]), .spi_sck_o(sck[1]), .spi_io_o(io_o[1]),
        .spi_io_oe_o(oe[1]), .spi_io_i(io_i[1])
    );

    typedef struct {
        int          inst;
        bit          wr;
        logic [71:0] frame;
        int          rises;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input bit ok, input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sniffer / responder / scoreboard monitor state
    logic [1:0]  prev_cs = 2'b11, prev_sck = 2'b00;
    int          rises [2] = '{0, 0};
    logic [71:0] cap   [2];
    bit          oe_bad[2] = '{0, 0};
    bit          cur_wr[2] = '{1, 1};
    logic [31:0] word  [2];
    int          gap   [2] = '{0, 0};
    bit          seen  [2] = '{0, 0};
    bit          pend  [2] = '{0, 0};
    int          last_rise[2] = '{0, 0};
    int          period[2] = '{0, 0};
    int          cyc = 0;
    int          busy_viol = 0;

    initial begin
        io_i[0] = 4'd0;
        io_i[1] = 4'd0;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 2; k++) begin
                int          dum;
                int          idx;
                logic [31:0] sh;
                exp_t        e;
                bit          fell;
                dum  = (k == 0) ? 8 : 0;
                fell = 1'b0;

                if (pend[k]) begin
                    chk(rspv[k] == 1'b0, $sformatf("rsp_pulse_width%0d", k), 72'(rspv[k]), 72'd0);
                    pend[k] = 1'b0;
                end

                if (prev_cs[k] && !cs_n[k]) begin
                    if (seen[k])
                        chk(gap[k] >= 4, $sformatf("cs_gap%0d", k), 72'(gap[k]), 72'd4);
                    seen[k]   = 1'b1;
                    rises[k]  = 0;
                    cap[k]    = '0;
                    oe_bad[k] = 1'b0;
                    cur_wr[k] = (sb.size() > 0) ? sb[0].wr : 1'b1;
                    word[k]   = (sb.size() > 0) ? sb[0].rdata : 32'd0;
                    fell      = 1'b1;
                end
                gap[k] = cs_n[k] ? gap[k] + 1 : 0;
                if (!cs_n[k] && ready[k]) busy_viol++;

                if (!prev_sck[k] && sck[k]) begin
                    if (rises[k] < 18) cap[k] = {cap[k][67:0], io_o[k]};
                    if (oe[k] != (cur_wr[k] ? 1'b1 : (rises[k] < 10))) oe_bad[k] = 1'b1;
                    if (rises[k] > 0) period[k] = cyc - last_rise[k];
                    last_rise[k] = cyc;
                    rises[k]++;
                end

                // Mode-0 target: present the nibble for the next rising edge after each falling edge.
                if (fell || (prev_sck[k] && !sck[k])) begin
                    idx = rises[k] - (10 + dum);
                    if (idx >= 0 && idx < 8) begin
                        sh = word[k] >> (4 * (7 - idx));
                        io_i[k] = sh[3:0];
                    end else begin
                        io_i[k] = 4'd0;
                    end
                end

                if (rspv[k]) begin
                    if (sb.size() == 0 || sb[0].inst != k) begin
                        chk(1'b0, $sformatf("unexpected_rsp%0d", k), 72'd1, 72'd0);
                    end else begin
                        e = sb.pop_front();
                        chk(rises[k] == e.rises, $sformatf("sck_rises%0d", k), 72'(rises[k]), 72'(e.rises));
                        if (e.wr)
                            chk(cap[k] == e.frame, $sformatf("wr_frame%0d", k), cap[k], e.frame);
                        else
                            chk(cap[k][71:32] == e.frame[71:32], $sformatf("rd_hdr%0d", k),
                                72'(cap[k][71:32]), 72'(e.frame[71:32]));
                        chk(!oe_bad[k], $sformatf("oe_profile%0d", k), 72'(oe_bad[k]), 72'd0);
                        chk(rdata[k] == e.rdata, $sformatf("rdata%0d", k), 72'(rdata[k]), 72'(e.rdata));
                        chk(period[k] == ((k == 0) ? 4 : 2), $sformatf("sck_period%0d", k),
                            72'(period[k]), 72'((k == 0) ? 4 : 2));
                        chk(cs_n[k] && !oe[k], $sformatf("cs_oe_at_rsp%0d", k), 72'({cs_n[k], oe[k]}), 72'b10);
                        pend[k] = 1'b1;
                    end
                end
            end
            prev_cs  = cs_n;
            prev_sck = sck;
        end
    end

    task automatic issue(input int k, input bit w, input logic [7:0] c, input logic [31:0] a,
                         input logic [31:0] d, input int nr, input logic [31:0] rd, input bit push);
        exp_t e;
        bit   ok;
        @(negedge clk);
        valid[k] = 1'b1;
        wr[k]    = w;
        cmd[k]   = c;
        addr[k]  = a;
        wd[k]    = d;
        if (push) begin
            e.inst  = k;
            e.wr    = w;
            e.frame = {c, a, w ? d : 32'd0};
            e.rises = nr;
            e.rdata = rd;
            sb.push_back(e);
        end
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (ready[k]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        else chk(1'b0, "accept_timeout", 72'd0, 72'd1);
    endtask

    task automatic drop(input int k);
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && ready[k]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "idle_timeout", 72'(sb.size()), 72'd0);
    endtask

    task automatic chk_reset(input int k, input string tag);
        chk(cs_n[k] == 1'b1, {tag, "_cs"}, 72'(cs_n[k]), 72'd1);
        chk(sck[k] == 1'b0, {tag, "_sck"}, 72'(sck[k]), 72'd0);
        chk(oe[k] == 1'b0, {tag, "_oe"}, 72'(oe[k]), 72'd0);
        chk(ready[k] == 1'b1, {tag, "_ready"}, 72'(ready[k]), 72'd1);
        chk(rspv[k] == 1'b0, {tag, "_rspv"}, 72'(rspv[k]), 72'd0);
        chk(io_o[k] == 4'd0, {tag, "_io"}, 72'(io_o[k]), 72'd0);
        chk(rdata[k] == 32'd0, {tag, "_rdata"}, 72'(rdata[k]), 72'd0);
    endtask

    initial begin
        bit hit;
        for (int k = 0; k < 2; k++) begin
            cmd[k] = '0; addr[k] = '0; wd[k] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset(0, "rst_a");
        chk_reset(1, "rst_b");

        issue(0, 1'b1, 8'h02, 32'h0000_1234, 32'hDEAD_BEEF, 18, 32'h0, 1'b1);
        drop(0);
        wait_idle(0);

        issue(0, 1'b0, 8'hEB, 32'h00AB_CDEF, 32'h0, 26, 32'hCAFE_F00D, 1'b1);
        drop(0);
        wait_idle(0);

        // Abort a write in the middle of its address phase.
        issue(0, 1'b1, 8'h02, 32'h0000_5678, 32'h1111_2222, 18, 32'h0, 1'b0);
        drop(0);
        hit = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (rises[0] == 5) begin
                hit = 1'b1;
                break;
            end
        end
        chk(hit, "reach_addr", 72'(rises[0]), 72'd5);
        rst_n = 1'b0;
        #1;
        chk_reset(0, "midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk(sb.size() == 0 && ready[0], "post_abort_idle", 72'(ready[0]), 72'd1);

        issue(1, 1'b0, 8'hEB, 32'h0000_0100, 32'h0, 18, 32'h1234_5678, 1'b1);
        drop(1);
        wait_idle(1);

        // Back-to-back: valid stays high across both requests.
        issue(0, 1'b0, 8'h0B, 32'h0000_0010, 32'h0, 26, 32'h1122_3344, 1'b1);
        issue(0, 1'b1, 8'h02, 32'h0000_0020, 32'h55AA_55AA, 18, 32'h1122_3344, 1'b1);
        drop(0);
        wait_idle(0);

        repeat (5) @(negedge clk);
        chk(sb.size() == 0, "sb_empty", 72'(sb.size()), 72'd0);
        chk(busy_viol == 0, "ready_while_busy", 72'(busy_viol), 72'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
